// File: rtl/roimager_pkg.sv
// Shared constants and types for the imager readout path (pixel packer, sequencer).
package roimager_pkg;

    localparam logic [7:0] HDR_TAG = 8'hF0;
    localparam logic [7:0] TRL_TAG = 8'hF1;

    localparam int unsigned C_NUM_MUX_DEF  = 46;
    localparam int unsigned C_NUM_ROWS_DEF = 160;

    typedef enum logic [1:0] {
        IDLE,
        ROW,
        TRAIL
    } pack_state_e;

    function automatic logic [31:0] ctl_word(input logic [7:0] tag, input logic [15:0] frame_cnt);
        return {tag, 8'h00, frame_cnt};
    endfunction

endpackage

// File: rtl/roimager_word_serializer.sv
// Holding register for one ADC sample strobe, emitted as an optional header plus
// C_NUM_ADC/2 data words; also muxes a single control word (trailer) when idle.
module roimager_word_serializer #(
    parameter int C_NUM_ADC  = 4,
    parameter int C_ADC_BITS = 12
) (
    input  logic                              ADC_CLK,
    input  logic                              RESET,
    input  logic                              load,
    input  logic                              load_hdr,
    input  logic [C_NUM_ADC*C_ADC_BITS-1:0]   sample,
    input  logic [31:0]                       hdr_word,
    input  logic                              trl_req,
    input  logic [31:0]                       trl_word,
    input  logic                              fifo_full,
    output logic [31:0]                       fifo_din,
    output logic                              fifo_wr,
    output logic                              busy,
    output logic                              last_wr,
    output logic                              trl_wr
);

    localparam int NW = C_NUM_ADC / 2;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    logic [C_NUM_ADC*C_ADC_BITS-1:0] hold;
    logic [IW-1:0]                   idx;
    logic                            occ;
    logic                            hdr_pend;
    logic [31:0]                     data_word;
    int unsigned                     base;

    assign busy = occ;

    always_comb begin
        base      = 32'(idx) * 32'(2 * C_ADC_BITS);
        data_word = '0;
        data_word[C_ADC_BITS-1:0]   = hold[base +: C_ADC_BITS];
        data_word[16 +: C_ADC_BITS] = hold[base + 32'(C_ADC_BITS) +: C_ADC_BITS];
    end

    // Sample words take priority; the trailer only goes out once the register is empty.
    always_comb begin
        fifo_din = '0;
        fifo_wr  = 1'b0;
        last_wr  = 1'b0;
        trl_wr   = 1'b0;
        if (occ) begin
            fifo_wr = ~fifo_full;
            if (hdr_pend) begin
                fifo_din = hdr_word;
            end else begin
                fifo_din = data_word;
                last_wr  = ~fifo_full && (idx == IW'(NW - 1));
            end
        end else if (trl_req) begin
            fifo_din = trl_word;
            fifo_wr  = ~fifo_full;
            trl_wr   = ~fifo_full;
        end
    end

    always_ff @(posedge ADC_CLK) begin
        if (RESET) begin
            occ      <= 1'b0;
            hdr_pend <= 1'b0;
            idx      <= '0;
            hold     <= '0;
        end else if (load) begin
            occ      <= 1'b1;
            hdr_pend <= load_hdr;
            idx      <= '0;
            hold     <= sample;
        end else if (occ && fifo_wr) begin
            if (hdr_pend) begin
                hdr_pend <= 1'b0;
            end else if (idx == IW'(NW - 1)) begin
                occ <= 1'b0;
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/roimager_pixel_packer.sv
// Packs TI-ADC sample strobes into framed 32-bit FIFO words (header, data, trailer).
// Define ROI_PACK_TESTPATTERN_EN to replace ADC_DOUT with a column-derived ramp.
module roimager_pixel_packer
    import roimager_pkg::*;
#(
    parameter int C_NUM_ADC  = 4,
    parameter int C_ADC_BITS = 12,
    parameter int C_NUM_MUX  = C_NUM_MUX_DEF,
    parameter int C_NUM_ROWS = C_NUM_ROWS_DEF
) (
    input  logic                            ADC_CLK,
    input  logic                            RESET,
    input  logic                            ADC_DATA_VALID,
    input  logic                            ADC_SAMPLE_STB,
    input  logic [C_NUM_ADC*C_ADC_BITS-1:0] ADC_DOUT,
    input  logic                            FIFO_FULL,
    output logic [31:0]                     FIFO_DIN,
    output logic                            FIFO_WR,
    output logic                            FRAME_DONE,
    output logic                            OVERFLOW,
    output logic                            ROW_ERR
);

    localparam int SW = C_NUM_ADC * C_ADC_BITS;

    pack_state_e state, state_nx;

    logic [15:0]   col;
    logic [15:0]   row;
    logic [15:0]   frame_cnt;
    logic          valid_q;
    logic          accept;
    logic          v_fall;
    logic          can_load;
    logic          ld;
    logic          ld_hdr;
    logic          drop;
    logic          col_inc;
    logic          row_end;
    logic          trl_req;
    logic          ser_busy;
    logic          ser_last;
    logic          trl_wr;
    logic [SW-1:0] sample;

`ifdef ROI_PACK_TESTPATTERN_EN
    always_comb begin
        sample = '0;
        for (int unsigned k = 0; k < C_NUM_ADC; k++) begin
            sample[k*C_ADC_BITS +: C_ADC_BITS] =
                C_ADC_BITS'(32'(col) * 32'(C_NUM_ADC) + 32'(k));
        end
    end
`else
    assign sample = ADC_DOUT;
`endif

    assign accept     = ADC_SAMPLE_STB & ADC_DATA_VALID;
    assign v_fall     = valid_q & ~ADC_DATA_VALID;
    assign can_load   = ~ser_busy | ser_last;
    assign FRAME_DONE = trl_wr;

    always_ff @(posedge ADC_CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        ld_hdr   = 1'b0;
        drop     = 1'b0;
        col_inc  = 1'b0;
        row_end  = 1'b0;
        trl_req  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    ld       = 1'b1;
                    ld_hdr   = 1'b1;
                    col_inc  = 1'b1;
                    state_nx = ROW;
                end
            end
            ROW: begin
                if (accept) begin
                    col_inc = 1'b1;
                    if (can_load) begin
                        ld = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (v_fall) begin
                    row_end = 1'b1;
                    if (row == 16'(C_NUM_ROWS - 1)) begin
                        state_nx = TRAIL;
                    end
                end
            end
            TRAIL: begin
                trl_req = 1'b1;
                if (trl_wr) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Dropped samples still advance col so row/frame alignment survives an overflow.
    always_ff @(posedge ADC_CLK) begin
        if (RESET) begin
            col       <= '0;
            row       <= '0;
            frame_cnt <= '0;
            valid_q   <= 1'b0;
            OVERFLOW  <= 1'b0;
            ROW_ERR   <= 1'b0;
        end else begin
            valid_q <= ADC_DATA_VALID;
            if (row_end) begin
                col <= '0;
                row <= (row == 16'(C_NUM_ROWS - 1)) ? '0 : row + 16'd1;
                if (col != 16'(C_NUM_MUX)) begin
                    ROW_ERR <= 1'b1;
                end
            end else if (col_inc) begin
                col <= col + 16'd1;
            end
            if (drop) begin
                OVERFLOW <= 1'b1;
            end
            if (trl_wr) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    roimager_word_serializer #(
        .C_NUM_ADC  (C_NUM_ADC),
        .C_ADC_BITS (C_ADC_BITS)
    ) u_ser (
        .ADC_CLK   (ADC_CLK),
        .RESET     (RESET),
        .load      (ld),
        .load_hdr  (ld_hdr),
        .sample    (sample),
        .hdr_word  (ctl_word(HDR_TAG, frame_cnt)),
        .trl_req   (trl_req),
        .trl_word  (ctl_word(TRL_TAG, frame_cnt)),
        .fifo_full (FIFO_FULL),
        .fifo_din  (FIFO_DIN),
        .fifo_wr   (FIFO_WR),
        .busy      (ser_busy),
        .last_wr   (ser_last),
        .trl_wr    (trl_wr)
    );

endmodule

// File: tb/tb_roimager_pixel_packer.sv
// Scoreboard bench for roimager_pixel_packer: stimulus pushes expected words, a monitor pops.
module tb_roimager_pixel_packer;

    localparam int NADC  = 4;
    localparam int BITS  = 12;
    localparam int NMUX  = 3;
    localparam int NROWS = 2;

`ifdef ROI_PACK_TESTPATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic                 ADC_CLK = 1'b0;
    logic                 RESET;
    logic                 ADC_DATA_VALID;
    logic                 ADC_SAMPLE_STB;
    logic [NADC*BITS-1:0] ADC_DOUT;
    logic                 FIFO_FULL;
    logic [31:0]          FIFO_DIN;
    logic                 FIFO_WR;
    logic                 FRAME_DONE;
    logic                 OVERFLOW;
    logic                 ROW_ERR;

    typedef struct packed {
        logic [31:0] word;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // ch3..ch0 = 4,3,2,1 / 0x800,0xFFF,0x123,0xABC / 0x00F,0x000,0xAAA,0x555
    localparam logic [47:0] D1  = {12'h004, 12'h003, 12'h002, 12'h001};
    localparam logic [47:0] D2  = {12'h800, 12'hFFF, 12'h123, 12'hABC};
    localparam logic [47:0] D3  = {12'h00F, 12'h000, 12'hAAA, 12'h555};

    always #5 ADC_CLK = ~ADC_CLK;

    roimager_pixel_packer #(
        .C_NUM_ADC  (NADC),
        .C_ADC_BITS (BITS),
        .C_NUM_MUX  (NMUX),
        .C_NUM_ROWS (NROWS)
    ) dut (
        .ADC_CLK        (ADC_CLK),
        .RESET          (RESET),
        .ADC_DATA_VALID (ADC_DATA_VALID),
        .ADC_SAMPLE_STB (ADC_SAMPLE_STB),
        .ADC_DOUT       (ADC_DOUT),
        .FIFO_FULL      (FIFO_FULL),
        .FIFO_DIN       (FIFO_DIN),
        .FIFO_WR        (FIFO_WR),
        .FRAME_DONE     (FRAME_DONE),
        .OVERFLOW       (OVERFLOW),
        .ROW_ERR        (ROW_ERR)
    );

    always @(negedge ADC_CLK) begin
        if (!RESET) begin
            if (FIFO_WR) begin
                n_cmp++;
                if (FIFO_FULL) begin
                    n_bad++;
                    $display("FAIL wr_while_full: FIFO_WR=1 with FIFO_FULL=1 word=%h", FIFO_DIN);
                end else if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got %h done=%0b, required no write", FIFO_DIN, FRAME_DONE);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (FIFO_DIN !== e.word || FRAME_DONE !== e.done) begin
                        n_bad++;
                        $display("FAIL fifo_word: got %h done=%0b, required %h done=%0b",
                                 FIFO_DIN, FRAME_DONE, e.word, e.done);
                    end
                end
            end else if (FRAME_DONE) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame_done_no_wr: FRAME_DONE=1 with FIFO_WR=0");
            end
        end
    end

    task automatic tick();
        @(posedge ADC_CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] tp_word(input int c, input int j);
        logic [11:0] lo, hi;
        lo = 12'(c * 4 + 2 * j);
        hi = 12'(c * 4 + 2 * j + 1);
        return {4'h0, hi, 4'h0, lo};
    endfunction

    task automatic push_word(input logic [31:0] w, input logic done);
        exp_q.push_back('{word: w, done: done});
    endtask

    task automatic push_data(input int c, input logic [31:0] w0, input logic [31:0] w1);
        push_word(TP ? tp_word(c, 0) : w0, 1'b0);
        push_word(TP ? tp_word(c, 1) : w1, 1'b0);
    endtask

    task automatic strobe(input logic [47:0] dout);
        ADC_SAMPLE_STB = 1'b1;
        ADC_DOUT       = dout;
        tick();
        ADC_SAMPLE_STB = 1'b0;
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_fifo_wr"},    32'(FIFO_WR),    32'd0);
        check({tag, "_fifo_din"},   FIFO_DIN,        32'd0);
        check({tag, "_frame_done"}, 32'(FRAME_DONE), 32'd0);
        check({tag, "_overflow"},   32'(OVERFLOW),   32'd0);
        check({tag, "_row_err"},    32'(ROW_ERR),    32'd0);
    endtask

    // Clean frame: NROWS windows of NMUX strobes, pixel period 3 cycles, stray
    // valid-low strobes between windows.
    task automatic full_frame(input logic [31:0] hdr, input logic [31:0] trl,
                              input logic [47:0] dout, input logic [31:0] w0,
                              input logic [31:0] w1);
        for (int r = 0; r < NROWS; r++) begin
            ADC_DATA_VALID = 1'b1;
            tick();
            for (int c = 0; c < NMUX; c++) begin
                if (r == 0 && c == 0) push_word(hdr, 1'b0);
                push_data(c, w0, w1);
                strobe(dout);
                if (r == 0 && c == 0) begin
                    @(negedge ADC_CLK);
                    check("first_wr_latency", 32'(FIFO_WR), 32'd1);
                    check("first_wr_header", FIFO_DIN, hdr);
                    @(posedge ADC_CLK);
                    #1;
                    tick();
                end else begin
                    tick();
                    tick();
                end
            end
            ADC_DATA_VALID = 1'b0;
            if (r == NROWS - 1) push_word(trl, 1'b1);
            tick();
            strobe(dout);
            tick();
            tick();
        end
        repeat (3) tick();
    endtask

    initial begin
        RESET          = 1'b1;
        ADC_DATA_VALID = 1'b0;
        ADC_SAMPLE_STB = 1'b0;
        ADC_DOUT       = '0;
        FIFO_FULL      = 1'b0;
        repeat (3) tick();
        @(negedge ADC_CLK);
        outputs_zero("reset");
        @(posedge ADC_CLK);
        #1;
        RESET = 1'b0;
        tick();

        // Strobes with valid low before any frame: no writes, frame count untouched.
        repeat (2) begin
            strobe(D1);
            tick();
        end
        @(negedge ADC_CLK);
        check("invalid_stb_no_wr", 32'(FIFO_WR), 32'd0);
        @(posedge ADC_CLK);
        #1;

        // Frame 0: clean frame.
        full_frame(32'hF000_0000, 32'hF100_0000, D1, 32'h0002_0001, 32'h0004_0003);
        check("f0_overflow", 32'(OVERFLOW), 32'd0);
        check("f0_row_err",  32'(ROW_ERR),  32'd0);

        // Frame 1, row 0: FIFO_FULL for 5 cycles during a drain, third strobe dropped.
        ADC_DATA_VALID = 1'b1;
        tick();
        push_word(32'hF000_0001, 1'b0);
        push_data(0, 32'h0123_0ABC, 32'h0800_0FFF);
        strobe(D2);
        tick();
        tick();
        push_data(1, 32'h0123_0ABC, 32'h0800_0FFF);
        strobe(D2);
        FIFO_FULL = 1'b1;
        tick();
        tick();
        check("overflow_before_drop", 32'(OVERFLOW), 32'd0);
        strobe(D2);
        tick();
        tick();
        FIFO_FULL = 1'b0;
        check("overflow_after_drop", 32'(OVERFLOW), 32'd1);
        tick();
        tick();
        ADC_DATA_VALID = 1'b0;
        tick();
        tick();
        check("row_err_full_row", 32'(ROW_ERR), 32'd0);

        // Frame 1, row 1: only 2 strobes, frame still closes after NROWS windows.
        ADC_DATA_VALID = 1'b1;
        tick();
        for (int c = 0; c < 2; c++) begin
            push_data(c, 32'h0123_0ABC, 32'h0800_0FFF);
            strobe(D2);
            tick();
            tick();
        end
        check("row_err_before_fall", 32'(ROW_ERR), 32'd0);
        ADC_DATA_VALID = 1'b0;
        push_word(32'hF100_0001, 1'b1);
        tick();
        @(negedge ADC_CLK);
        check("row_err_at_fall", 32'(ROW_ERR), 32'd1);
        check("trailer_done", 32'(FRAME_DONE), 32'd1);
        @(posedge ADC_CLK);
        #1;
        repeat (2) tick();
        check("overflow_sticky", 32'(OVERFLOW), 32'd1);

        // Frame 2: reset mid-row after one sample; no trailer may follow.
        ADC_DATA_VALID = 1'b1;
        tick();
        push_word(32'hF000_0002, 1'b0);
        push_data(0, 32'h0002_0001, 32'h0004_0003);
        strobe(D1);
        repeat (3) tick();
        RESET          = 1'b1;
        ADC_SAMPLE_STB = 1'b1;
        tick();
        RESET          = 1'b0;
        ADC_SAMPLE_STB = 1'b0;
        ADC_DATA_VALID = 1'b0;
        @(negedge ADC_CLK);
        outputs_zero("mid_reset");
        @(posedge ADC_CLK);
        #1;
        repeat (4) tick();

        // Frame after reset restarts at frame count 0.
        full_frame(32'hF000_0000, 32'hF100_0000, D3, 32'h0AAA_0555, 32'h000F_0000);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
